// File: rtl/calc_req_dispatcher.sv
// Request dispatcher: buffers host requests and issues each as a two-beat calc transaction, broadcast or round-robin,
// with per-port outstanding-tag tracking. Optional counters enabled by define CALC_DISPATCH_STATS_EN.
`timescale 1ns/1ps

module calc_req_dispatcher #(
  parameter int unsigned NUM_PORTS = 4,
  parameter int unsigned CMD_W     = 4,
  parameter int unsigned DATA_W    = 32,
  parameter int unsigned TAG_W     = 2,
  parameter int unsigned DEPTH     = 4
) (
  input  logic                          PClk,
  input  logic                          Rst,
  input  logic                          mode,
  input  logic                          in_valid,
  output logic                          in_ready,
  input  logic [CMD_W-1:0]              in_cmd,
  input  logic [TAG_W-1:0]              in_tag,
  input  logic [DATA_W-1:0]             in_data1,
  input  logic [DATA_W-1:0]             in_data2,
  output logic [NUM_PORTS*CMD_W-1:0]    req_cmd,
  output logic [NUM_PORTS*DATA_W-1:0]   req_data,
  output logic [NUM_PORTS*TAG_W-1:0]    req_tag,
  input  logic [NUM_PORTS*2-1:0]        out_resp,
  input  logic [NUM_PORTS*TAG_W-1:0]    out_tag,
  output logic                          busy
`ifdef CALC_DISPATCH_STATS_EN
  ,
  output logic [15:0]                   issue_cnt,
  output logic [15:0]                   stall_cnt
`endif
);

  localparam int unsigned NUM_TAGS = 1 << TAG_W;
  localparam int unsigned PTR_W    = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CNT_W    = PTR_W + 1;
  localparam int unsigned RR_W     = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1;
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);
  localparam logic [RR_W-1:0]  RR_LAST  = RR_W'(NUM_PORTS - 1);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_BEAT1 = 2'd1,
    ST_BEAT2 = 2'd2
  } state_e;

  state_e state_q, state_d;

  // Request FIFO storage (data only, no reset needed)
  logic [CMD_W-1:0]  fifo_cmd_q   [DEPTH];
  logic [TAG_W-1:0]  fifo_tag_q   [DEPTH];
  logic [DATA_W-1:0] fifo_data1_q [DEPTH];
  logic [DATA_W-1:0] fifo_data2_q [DEPTH];

  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             in_ready_q, in_ready_d;
  logic             busy_q, busy_d;
  logic [RR_W-1:0]  rr_ptr_q, rr_ptr_d;

  logic [NUM_PORTS-1:0]              mask_q, mask_d;
  logic [DATA_W-1:0]                 data2_q, data2_d;
  logic [NUM_PORTS-1:0][NUM_TAGS-1:0] outst_q, outst_d, outst_set, outst_clr;

  logic [NUM_PORTS*CMD_W-1:0]  req_cmd_q, req_cmd_d;
  logic [NUM_PORTS*DATA_W-1:0] req_data_q, req_data_d;
  logic [NUM_PORTS*TAG_W-1:0]  req_tag_q, req_tag_d;

  logic [CMD_W-1:0]     head_cmd;
  logic [TAG_W-1:0]     head_tag;
  logic [DATA_W-1:0]    head_data1;
  logic [DATA_W-1:0]    head_data2;
  logic                 fifo_empty;
  logic                 push_store;
  logic                 tag_blocked;
  logic                 eligible;
  logic                 issue;
  logic [NUM_PORTS-1:0] tgt_mask;

  always_comb begin
    head_cmd   = fifo_cmd_q[rd_ptr_q];
    head_tag   = fifo_tag_q[rd_ptr_q];
    head_data1 = fifo_data1_q[rd_ptr_q];
    head_data2 = fifo_data2_q[rd_ptr_q];
    fifo_empty = (count_q == '0);
    // Zero-command requests are acknowledged but never stored
    push_store = in_valid && in_ready_q && (in_cmd != '0);
  end

  // Target ports for the head entry and whether its tag is free on all of them
  always_comb begin
    tgt_mask = '0;
    if (mode) begin
      tgt_mask[rr_ptr_q] = 1'b1;
    end else begin
      tgt_mask = '1;
    end
    tag_blocked = 1'b0;
    for (int unsigned p = 0; p < NUM_PORTS; p++) begin
      if (tgt_mask[p] && outst_q[p][head_tag]) begin
        tag_blocked = 1'b1;
      end
    end
    eligible = !fifo_empty && !tag_blocked;
    issue    = eligible && (state_q != ST_BEAT1);
  end

  // Next state and next registered beat outputs
  always_comb begin
    state_d    = state_q;
    req_cmd_d  = '0;
    req_data_d = '0;
    req_tag_d  = '0;
    mask_d     = mask_q;
    data2_d    = data2_q;

    case (state_q)
      ST_IDLE:  if (eligible) state_d = ST_BEAT1;
      ST_BEAT1: state_d = ST_BEAT2;
      ST_BEAT2: state_d = eligible ? ST_BEAT1 : ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase

    if (issue) begin
      mask_d  = tgt_mask;
      data2_d = head_data2;
      for (int unsigned p = 0; p < NUM_PORTS; p++) begin
        if (tgt_mask[p]) begin
          req_cmd_d[p*CMD_W +: CMD_W]    = head_cmd;
          req_data_d[p*DATA_W +: DATA_W] = head_data1;
          req_tag_d[p*TAG_W +: TAG_W]    = head_tag;
        end
      end
    end else if (state_q == ST_BEAT1) begin
      for (int unsigned p = 0; p < NUM_PORTS; p++) begin
        if (mask_q[p]) begin
          req_data_d[p*DATA_W +: DATA_W] = data2_q;
        end
      end
    end
  end

  // Outstanding tag bitmap: responses clear, issues set, set wins on collision
  always_comb begin
    outst_set = '0;
    outst_clr = '0;
    for (int unsigned p = 0; p < NUM_PORTS; p++) begin
      if (issue && tgt_mask[p]) begin
        outst_set[p][head_tag] = 1'b1;
      end
      if (out_resp[p*2 +: 2] != 2'b00) begin
        outst_clr[p][out_tag[p*TAG_W +: TAG_W]] = 1'b1;
      end
    end
    outst_d = (outst_q & ~outst_clr) | outst_set;
  end

  always_comb begin
    wr_ptr_d   = push_store ? wr_ptr_q + PTR_W'(1) : wr_ptr_q;
    rd_ptr_d   = issue ? rd_ptr_q + PTR_W'(1) : rd_ptr_q;
    count_d    = count_q + CNT_W'(push_store) - CNT_W'(issue);
    in_ready_d = (count_d != FULL_CNT);
    rr_ptr_d   = rr_ptr_q;
    if (issue) begin
      rr_ptr_d = (rr_ptr_q == RR_LAST) ? '0 : rr_ptr_q + RR_W'(1);
    end
    busy_d = (count_d != '0) || (state_d != ST_IDLE) || (|outst_d);
  end

  always_ff @(posedge PClk or negedge Rst) begin
    if (!Rst) begin
      state_q    <= ST_IDLE;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      in_ready_q <= 1'b1;
      busy_q     <= 1'b0;
      rr_ptr_q   <= '0;
      mask_q     <= '0;
      data2_q    <= '0;
      outst_q    <= '0;
      req_cmd_q  <= '0;
      req_data_q <= '0;
      req_tag_q  <= '0;
    end else begin
      state_q    <= state_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      in_ready_q <= in_ready_d;
      busy_q     <= busy_d;
      rr_ptr_q   <= rr_ptr_d;
      mask_q     <= mask_d;
      data2_q    <= data2_d;
      outst_q    <= outst_d;
      req_cmd_q  <= req_cmd_d;
      req_data_q <= req_data_d;
      req_tag_q  <= req_tag_d;
    end
  end

  always_ff @(posedge PClk) begin
    if (push_store) begin
      fifo_cmd_q[wr_ptr_q]   <= in_cmd;
      fifo_tag_q[wr_ptr_q]   <= in_tag;
      fifo_data1_q[wr_ptr_q] <= in_data1;
      fifo_data2_q[wr_ptr_q] <= in_data2;
    end
  end

  assign in_ready = in_ready_q;
  assign busy     = busy_q;
  assign req_cmd  = req_cmd_q;
  assign req_data = req_data_q;
  assign req_tag  = req_tag_q;

`ifdef CALC_DISPATCH_STATS_EN
  logic [15:0] issue_cnt_q, issue_cnt_d;
  logic [15:0] stall_cnt_q, stall_cnt_d;

  // Saturating issue and stall counters
  always_comb begin
    issue_cnt_d = issue_cnt_q;
    stall_cnt_d = stall_cnt_q;
    if (issue && (issue_cnt_q != 16'hFFFF)) begin
      issue_cnt_d = issue_cnt_q + 16'd1;
    end
    if ((state_q == ST_IDLE) && !fifo_empty && !eligible && (stall_cnt_q != 16'hFFFF)) begin
      stall_cnt_d = stall_cnt_q + 16'd1;
    end
  end

  always_ff @(posedge PClk or negedge Rst) begin
    if (!Rst) begin
      issue_cnt_q <= '0;
      stall_cnt_q <= '0;
    end else begin
      issue_cnt_q <= issue_cnt_d;
      stall_cnt_q <= stall_cnt_d;
    end
  end

  assign issue_cnt = issue_cnt_q;
  assign stall_cnt = stall_cnt_q;
`endif

endmodule

// File: tb/tb_calc_req_dispatcher.sv
// Self-checking bench for calc_req_dispatcher: queue-based reference model checked every cycle plus directed literals.
`timescale 1ns/1ps

module tb_calc_req_dispatcher;

  localparam int NP = 4;
  localparam int CW = 4;
  localparam int DW = 32;
  localparam int TW = 2;
  localparam int DP = 4;
  localparam int NT = 4;

  logic              PClk = 1'b0;
  logic              Rst = 1'b1;
  logic              mode = 1'b0;
  logic              in_valid = 1'b0;
  logic              in_ready;
  logic [CW-1:0]     in_cmd = '0;
  logic [TW-1:0]     in_tag = '0;
  logic [DW-1:0]     in_data1 = '0;
  logic [DW-1:0]     in_data2 = '0;
  logic [NP*CW-1:0]  req_cmd;
  logic [NP*DW-1:0]  req_data;
  logic [NP*TW-1:0]  req_tag;
  logic [NP*2-1:0]   out_resp = '0;
  logic [NP*TW-1:0]  out_tag = '0;
  logic              busy;
`ifdef CALC_DISPATCH_STATS_EN
  logic [15:0]       issue_cnt;
  logic [15:0]       stall_cnt;
`endif

  calc_req_dispatcher #(
    .NUM_PORTS(NP), .CMD_W(CW), .DATA_W(DW), .TAG_W(TW), .DEPTH(DP)
  ) dut (
    .PClk(PClk), .Rst(Rst), .mode(mode), .in_valid(in_valid), .in_ready(in_ready),
    .in_cmd(in_cmd), .in_tag(in_tag), .in_data1(in_data1), .in_data2(in_data2),
    .req_cmd(req_cmd), .req_data(req_data), .req_tag(req_tag),
    .out_resp(out_resp), .out_tag(out_tag), .busy(busy)
`ifdef CALC_DISPATCH_STATS_EN
    , .issue_cnt(issue_cnt), .stall_cnt(stall_cnt)
`endif
  );

  always #5 PClk = ~PClk;

  int n_chk = 0;
  int n_fail = 0;
  bit chk_en = 1'b0;
  int iss_ports[$];

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: request queue, tag table and "what happened last cycle"
  typedef struct packed {
    logic [CW-1:0] cmd;
    logic [TW-1:0] tag;
    logic [DW-1:0] d1;
    logic [DW-1:0] d2;
  } req_t;

  req_t             mq[$];
  bit               m_out [NP][NT];
  int               m_rr = 0;
  int               m_kind = 0;  // 0 nothing, 1 first beat driven, 2 second beat driven
  logic [NP-1:0]    m_mask = '0;
  logic [DW-1:0]    m_d2 = '0;
  logic [NP*CW-1:0] e_cmd = '0;
  logic [NP*DW-1:0] e_data = '0;
  logic [NP*TW-1:0] e_tag = '0;
  logic             e_ready = 1'b1;
  logic             e_busy = 1'b0;
  int               e_issue = 0;
  int               e_stall = 0;

  task automatic model_reset();
    mq.delete();
    for (int p = 0; p < NP; p++)
      for (int t = 0; t < NT; t++) m_out[p][t] = 1'b0;
    m_rr = 0; m_kind = 0; m_mask = '0; m_d2 = '0;
    e_cmd = '0; e_data = '0; e_tag = '0;
    e_ready = 1'b1; e_busy = 1'b0; e_issue = 0; e_stall = 0;
  endtask

  task automatic model_step();
    req_t          h;
    logic [NP-1:0] tmask;
    bit            ok;
    bit            iss;
    bit            any;
    int            nk;
    h = '0; tmask = '0; iss = 1'b0; nk = 0;
    e_cmd = '0; e_data = '0; e_tag = '0;
    if (m_kind == 1) begin
      nk = 2;
      for (int p = 0; p < NP; p++) if (m_mask[p]) e_data[p*DW +: DW] = m_d2;
    end else if (mq.size() > 0) begin
      h = mq[0];
      if (mode) tmask[m_rr] = 1'b1;
      else tmask = '1;
      ok = 1'b1;
      for (int p = 0; p < NP; p++) if (tmask[p] && m_out[p][h.tag]) ok = 1'b0;
      if (ok) begin
        iss = 1'b1;
        nk = 1;
        void'(mq.pop_front());
        for (int p = 0; p < NP; p++) begin
          if (tmask[p]) begin
            e_cmd[p*CW +: CW] = h.cmd;
            e_data[p*DW +: DW] = h.d1;
            e_tag[p*TW +: TW] = h.tag;
          end
        end
        m_mask = tmask;
        m_d2 = h.d2;
        m_rr = (m_rr + 1) % NP;
        if (e_issue < 65535) e_issue++;
      end else if (m_kind == 0 && e_stall < 65535) begin
        e_stall++;
      end
    end
    for (int p = 0; p < NP; p++)
      if (out_resp[p*2 +: 2] != 2'b00) m_out[p][out_tag[p*TW +: TW]] = 1'b0;
    if (iss)
      for (int p = 0; p < NP; p++) if (tmask[p]) m_out[p][h.tag] = 1'b1;
    if (in_valid && e_ready && in_cmd != '0)
      mq.push_back('{cmd: in_cmd, tag: in_tag, d1: in_data1, d2: in_data2});
    m_kind = nk;
    e_ready = (mq.size() < DP);
    any = 1'b0;
    for (int p = 0; p < NP; p++)
      for (int t = 0; t < NT; t++) any |= m_out[p][t];
    e_busy = (mq.size() != 0) || (nk != 0) || any;
  endtask

  initial begin
    forever begin
      @(posedge PClk or negedge Rst);
      if (!Rst) model_reset();
      else model_step();
    end
  end

  // Per-cycle compare against the model, plus a log of ports receiving a first beat
  always @(negedge PClk) begin
    if (chk_en) begin
      chk("req_cmd", 128'(req_cmd), 128'(e_cmd));
      chk("req_data", 128'(req_data), 128'(e_data));
      chk("req_tag", 128'(req_tag), 128'(e_tag));
      chk("in_ready", 128'(in_ready), 128'(e_ready));
      chk("busy", 128'(busy), 128'(e_busy));
`ifdef CALC_DISPATCH_STATS_EN
      chk("issue_cnt", 128'(issue_cnt), 128'(e_issue));
      chk("stall_cnt", 128'(stall_cnt), 128'(e_stall));
`endif
    end
    for (int p = 0; p < NP; p++) if (req_cmd[p*CW +: CW] != '0) iss_ports.push_back(p);
  end

  task automatic tick();
    @(negedge PClk);
    #1;
  endtask

  task automatic do_reset();
    Rst = 1'b0;
    in_valid = 1'b0;
    out_resp = '0;
    out_tag = '0;
    tick();
    Rst = 1'b1;
    tick();
    iss_ports.delete();
  endtask

  task automatic push(input logic [CW-1:0] c, input logic [TW-1:0] t,
                      input logic [DW-1:0] a, input logic [DW-1:0] b);
    int n;
    n = 0;
    in_valid = 1'b1; in_cmd = c; in_tag = t; in_data1 = a; in_data2 = b;
    while (!in_ready && n < 50) begin
      tick();
      n++;
    end
    chk("push_ready", 128'(in_ready), 128'(1'b1));
    tick();
    in_valid = 1'b0;
  endtask

  task automatic resp(input logic [NP-1:0] pmask, input logic [TW-1:0] t);
    for (int p = 0; p < NP; p++) begin
      out_resp[p*2 +: 2] = pmask[p] ? 2'b01 : 2'b00;
      out_tag[p*TW +: TW] = t;
    end
    tick();
    out_resp = '0;
    out_tag = '0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, time %0t", $time);
    $fatal(1);
  end

  initial begin
    #1 Rst = 1'b0;
    tick();
    Rst = 1'b1;
    tick();
    chk_en = 1'b1;

    // Reset then idle
    do_reset();
    tick();
    chk("rst_cmd", 128'(req_cmd), 128'(0));
    chk("rst_data", 128'(req_data), 128'(0));
    chk("rst_ready", 128'(in_ready), 128'(1'b1));
    chk("rst_busy", 128'(busy), 128'(1'b0));

    // Broadcast single request, latency and both beats
    mode = 1'b0;
    push(4'd1, 2'd0, 32'd5, 32'd3);
    chk("bc_latency", 128'(req_cmd), 128'(0));
    tick();
    chk("bc_b1_cmd", 128'(req_cmd), 128'({4{4'h1}}));
    chk("bc_b1_data", 128'(req_data), 128'({4{32'd5}}));
    chk("bc_b1_tag", 128'(req_tag), 128'(0));
    tick();
    chk("bc_b2_cmd", 128'(req_cmd), 128'(0));
    chk("bc_b2_data", 128'(req_data), 128'({4{32'd3}}));
    tick();
    chk("bc_busy_outst", 128'(busy), 128'(1'b1));
    resp(4'hF, 2'd0);
    chk("bc_busy_clear", 128'(busy), 128'(1'b0));
    push(4'd0, 2'd1, 32'd1, 32'd1);
    repeat (3) tick();
    chk("discard_cmd", 128'(req_cmd), 128'(0));
    chk("discard_busy", 128'(busy), 128'(1'b0));

    // Round-robin ordering; fifth waits for port 0 tag 0
    do_reset();
    mode = 1'b1;
    for (int i = 0; i < 5; i++) push(CW'(i + 1), TW'(i % 4), DW'(16 * i + 1), DW'(16 * i + 2));
    repeat (8) tick();
    chk("rr_count4", 128'(iss_ports.size()), 128'(4));
    for (int i = 0; i < 4 && i < iss_ports.size(); i++) chk("rr_port", 128'(iss_ports[i]), 128'(i));
    resp(4'b0001, 2'd0);
    chk("rr_still_wait", 128'(iss_ports.size()), 128'(4));
    tick();
    chk("rr_count5", 128'(iss_ports.size()), 128'(5));
    if (iss_ports.size() == 5) chk("rr_port5", 128'(iss_ports[4]), 128'(0));
    repeat (2) tick();

    // FIFO full behind a blocked tag
    do_reset();
    mode = 1'b0;
    push(4'd1, 2'd0, 32'h10, 32'h11);
    for (int i = 0; i < 4; i++) push(4'd2, 2'd0, DW'(32'h20 + i), DW'(32'h30 + i));
    chk("full_ready0", 128'(in_ready), 128'(1'b0));
    in_valid = 1'b1; in_cmd = 4'd3; in_tag = 2'd0; in_data1 = 32'h40; in_data2 = 32'h41;
    repeat (3) tick();
    chk("full_held", 128'(in_ready), 128'(1'b0));
    resp(4'hF, 2'd0);
    chk("full_ready_before_pop", 128'(in_ready), 128'(1'b0));
    tick();
    chk("full_ready_after_pop", 128'(in_ready), 128'(1'b1));
    tick();
    in_valid = 1'b0;
    repeat (3) tick();

    // Response and issue hit the same tag bit in one cycle
    do_reset();
    mode = 1'b0;
    push(4'd1, 2'd2, 32'h7, 32'h8);
    out_resp[1*2 +: 2] = 2'b10;
    out_tag[1*TW +: TW] = 2'd2;
    tick();
    out_resp = '0;
    out_tag = '0;
    push(4'd2, 2'd2, 32'h9, 32'hA);
    repeat (3) tick();
    chk("coll_blocked", 128'(iss_ports.size()), 128'(4));
    chk("coll_busy", 128'(busy), 128'(1'b1));
    resp(4'b1101, 2'd2);
    repeat (2) tick();
    chk("coll_still_blocked", 128'(iss_ports.size()), 128'(4));
    resp(4'b0010, 2'd2);
    tick();
    chk("coll_released", 128'(iss_ports.size()), 128'(8));
    repeat (2) tick();

    // Mode is sampled at issue only
    do_reset();
    mode = 1'b1;
    push(4'd5, 2'd1, 32'hA1, 32'hA2);
    push(4'd6, 2'd3, 32'hB1, 32'hB2);
    mode = 1'b0;
    tick();
    chk("mode_b2_latched", 128'(req_data), 128'(32'hA2));
    tick();
    chk("mode_bc_next", 128'(req_cmd), 128'({4{4'h6}}));
    repeat (3) tick();

    // Reset asserted while the first beat is on the bus
    do_reset();
    mode = 1'b0;
    push(4'd3, 2'd1, 32'd11, 32'd12);
    push(4'd4, 2'd2, 32'd13, 32'd14);
    chk("rstmid_beat1", 128'(req_cmd), 128'({4{4'h3}}));
    Rst = 1'b0;
    #1;
    chk("rstmid_cmd", 128'(req_cmd), 128'(0));
    chk("rstmid_busy", 128'(busy), 128'(1'b0));
    chk("rstmid_ready", 128'(in_ready), 128'(1'b1));
`ifdef CALC_DISPATCH_STATS_EN
    chk("rstmid_issue", 128'(issue_cnt), 128'(0));
    chk("rstmid_stall", 128'(stall_cnt), 128'(0));
`endif
    tick();
    Rst = 1'b1;
    iss_ports.delete();
    repeat (4) tick();
    chk("rstmid_no_beat2", 128'(iss_ports.size()), 128'(0));
    chk("rstmid_data", 128'(req_data), 128'(0));

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
